// File: rtl/mux_pkg.sv
// Shared definitions for the four-lane data selector family.
package mux_pkg;

  localparam int N_LANES = 4;
  localparam int SEL_W   = 2;

  typedef logic [SEL_W-1:0] sel_t;

endpackage : mux_pkg

// File: rtl/mux_4to1_comb.sv
// Purely combinational lane selector: Y = I[S*DW +: DW], valid without any clock.
module mux_4to1_comb
  import mux_pkg::*;
#(
  parameter int DW = 1
) (
  input  logic [N_LANES*DW-1:0] I,
  input  sel_t                  S,
  output logic [DW-1:0]         Y
);

  logic [DW-1:0] lanes [N_LANES];

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    assign lanes[k] = I[k*DW +: DW];
  end

  // An unknown select indexes out of the known lanes, so Y goes X in a 4-state simulator.
  assign Y = lanes[S];

endmodule : mux_4to1_comb

// File: rtl/mux_4to1.sv
// Four-lane selector with combinational output plus registered shadow copy and select-change pulse.
module mux_4to1
  import mux_pkg::*;
#(
  parameter int DW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_LANES*DW-1:0] I,
  input  sel_t                  S,
  output logic [DW-1:0]         Y,
  output logic [DW-1:0]         Y_r,
  output logic                  sel_chg
);

  sel_t S_q;

  mux_4to1_comb #(.DW(DW)) u_comb (
    .I (I),
    .S (S),
    .Y (Y)
  );

  // NOTE: every register here is cleared by reset so the shadow outputs are known before the first edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y_r     <= '0;
      S_q     <= '0;
      sel_chg <= 1'b0;
    end else begin
      // NOTE: non-blocking so sel_chg compares against the S_q of the previous edge, not the new one.
      Y_r     <= Y;
      S_q     <= S;
      sel_chg <= (S != S_q);
    end
  end

endmodule : mux_4to1

// File: tb/tb_mux_4to1.sv
// Self-checking bench for mux_4to1: directed checks plus a randomized scoreboard against a lane model.
module tb_mux_4to1;

  localparam int DW = 8;

  logic            clk;
  logic            clk_en;
  logic            rst_n;
  logic [4*DW-1:0] I;
  logic [1:0]      S;
  logic [DW-1:0]   Y;
  logic [DW-1:0]   Y_r;
  logic            sel_chg;

  int checks   = 0;
  int failures = 0;
  bit sb_on    = 1'b0;

  typedef struct {
    logic [DW-1:0] yr;
    logic          chg;
  } exp_t;

  exp_t exp_q[$];

  mux_4to1 #(.DW(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .I       (I),
    .S       (S),
    .Y       (Y),
    .Y_r     (Y_r),
    .sel_chg (sel_chg)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: lane s is the byte at bit offset 8*s of the packed lane bus.
  function automatic logic [DW-1:0] ref_lane(input logic [4*DW-1:0] lanes, input int s);
    logic [4*DW-1:0] shifted;
    shifted = lanes >> (DW * s);
    return shifted[DW-1:0];
  endfunction

  // Monitor: compares the registered outputs with the expectation queued for this edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_on && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_y_r", 32'(Y_r), 32'(e.yr));
      check("sb_sel_chg", 32'(sel_chg), 32'(e.chg));
    end
  end

  initial begin
    int prev_s;
    int wait_edges;
    exp_t e;

    clk_en = 1'b0;
    rst_n  = 1'b0;
    I      = '0;
    S      = 2'd0;
    #1;
    check("reset_y_r", 32'(Y_r), 32'h0);
    check("reset_sel_chg", 32'(sel_chg), 32'h0);

    // Combinational path with the clock never toggling.
    #10;
    I = {8'h01, 8'h01, 8'h01, 8'h00};
    #1 check("comb_s0_1110", 32'(Y), 32'h00);
    #10 S = 2'd1; #1 check("comb_s1_1110", 32'(Y), 32'h01);
    #10 S = 2'd2; #1 check("comb_s2_1110", 32'(Y), 32'h01);
    #10 S = 2'd3; #1 check("comb_s3_1110", 32'(Y), 32'h01);

    I = {8'h00, 8'h01, 8'h00, 8'h01};
    for (int s = 0; s < 4; s++) begin
      S = 2'(s);
      #1 check("comb_sweep_0101", 32'(Y), (s % 2 == 0) ? 32'h01 : 32'h00);
    end
    I = {8'h01, 8'h00, 8'h01, 8'h00};
    #1 check("comb_i_change_s3", 32'(Y), 32'h01);

    // Clocked behaviour.
    I = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    S = 2'd2;
    #1 check("y_lane2", 32'(Y), 32'hCC);
    clk_en = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    check("first_edge_y_r", 32'(Y_r), 32'hCC);
    check("first_edge_sel_chg", 32'(sel_chg), 32'h1);
    @(posedge clk) #1;
    check("held_sel_chg", 32'(sel_chg), 32'h0);
    check("held_y_r", 32'(Y_r), 32'hCC);

    @(negedge clk) rst_n = 1'b0;
    #1;
    check("async_rst_y_r", 32'(Y_r), 32'h0);
    check("async_rst_sel_chg", 32'(sel_chg), 32'h0);
    check("async_rst_y", 32'(Y), 32'hCC);

    S = 2'd1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    check("release_sel_chg", 32'(sel_chg), 32'h1);
    check("release_y_r", 32'(Y_r), 32'hBB);

    @(negedge clk) S = 2'd2;
    @(posedge clk) #1;
    check("chg_1to2", 32'(sel_chg), 32'h1);
    @(negedge clk) S = 2'd3;
    @(posedge clk) #1;
    check("chg_2to3", 32'(sel_chg), 32'h1);
    check("chg_2to3_y_r", 32'(Y_r), 32'hDD);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk) #1;
      check("hold_after_chg", 32'(sel_chg), 32'h0);
    end

    // Randomized scoreboard phase, with occasional select glitches between edges.
    prev_s = 3;
    sb_on  = 1'b1;
    for (int n = 0; n < 300; n++) begin
      int s_new;
      @(posedge clk);
      #2;
      if ($urandom_range(3) == 0) begin
        S = 2'($urandom);
        #1;
      end
      I     = $urandom;
      s_new = $urandom_range(3);
      if ($urandom_range(4) == 0) s_new = prev_s;
      S = 2'(s_new);
      #1 check("rand_y_comb", 32'(Y), 32'(ref_lane(I, s_new)));
      e.yr  = ref_lane(I, s_new);
      e.chg = (s_new != prev_s);
      prev_s = s_new;
      exp_q.push_back(e);
    end

    wait_edges = 0;
    while (exp_q.size() > 0 && wait_edges < 5) begin
      @(posedge clk) #3;
      wait_edges++;
    end
    check("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mux_4to1
